// File: rtl/decode_hazard_ctrl.sv
// Decode stage owning the ID/EX register and flag register, with load-use/branch hazard
// detection, branch resolution and halt FSM. Define DECODE_PERF_CNT_EN for perf counters.
module decode_hazard_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fd_valid,
  input  logic [15:0]       fd_instr,
  input  logic [DATA_W-1:0] fd_pc2,
  output logic [REG_AW-1:0] rf_rs1,
  output logic [REG_AW-1:0] rf_rs2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic              ex_flag_we,
  input  logic [2:0]        ex_flags,
  output logic              stall,
  output logic              flush,
  output logic [DATA_W-1:0] branch_target,
  output logic              halt,
  output logic              dx_valid,
  output logic [DATA_W-1:0] dx_rd1,
  output logic [DATA_W-1:0] dx_rd2,
  output logic [DATA_W-1:0] dx_imm,
  output logic [REG_AW-1:0] dx_rs1,
  output logic [REG_AW-1:0] dx_rs2,
  output logic [REG_AW-1:0] dx_rd,
  output logic [11:0]       dx_ctrl
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_taken_cnt
`endif
);

  localparam logic [3:0] OpLw  = 4'h8;
  localparam logic [3:0] OpSw  = 4'h9;
  localparam logic [3:0] OpLlb = 4'hA;
  localparam logic [3:0] OpLhb = 4'hB;
  localparam logic [3:0] OpB   = 4'hC;
  localparam logic [3:0] OpBr  = 4'hD;
  localparam logic [3:0] OpPcs = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e state_q, state_d;

  logic [3:0]        op;
  logic [2:0]        cc;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              is_b, is_br, is_pcs;
  logic              use_rs1, use_rs2;
  logic [3:0]        aluop;
  logic              alusrc, memtoreg, pcs, regwrite, memwrite, memread, flag_en, hlt;
  logic [11:0]       ctrl;
  logic [DATA_W-1:0] imm, b_tgt;
  logic [2:0]        flags_q;
  logic              cond;
  logic              run, hz_load, hz_flag, hz_br, hazard, issue;

  logic              dx_valid_q;
  logic [DATA_W-1:0] dx_rd1_q, dx_rd2_q, dx_imm_q;
  logic [REG_AW-1:0] dx_rs1_q, dx_rs2_q, dx_rd_q;
  logic [11:0]       dx_ctrl_q;
  logic              xm_wr_q;
  logic [REG_AW-1:0] xm_rd_q;

  assign op     = fd_instr[15:12];
  assign cc     = fd_instr[11:9];
  assign is_b   = (op == OpB);
  assign is_br  = (op == OpBr);
  assign is_pcs = (op == OpPcs);
  assign rd     = REG_AW'(fd_instr[11:8]);
  assign rs1    = (op == OpLlb || op == OpLhb) ? REG_AW'(fd_instr[11:8]) : REG_AW'(fd_instr[7:4]);
  assign rs2    = (op == OpLw || op == OpSw) ? REG_AW'(fd_instr[11:8]) : REG_AW'(fd_instr[3:0]);
  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;
  assign b_tgt  = fd_pc2 + (DATA_W'($signed(fd_instr[8:0])) << 1);

  // Control/immediate decode; use_rs* mark sources the instruction actually reads.
  always_comb begin
    aluop    = op;
    alusrc   = 1'b0;
    memtoreg = 1'b0;
    pcs      = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;
    memread  = 1'b0;
    flag_en  = 1'b0;
    hlt      = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    imm      = '0;
    case (op)
      4'h0, 4'h1, 4'h2: begin
        regwrite = 1'b1;
        flag_en  = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      4'h3, 4'h7: begin
        regwrite = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      4'h4, 4'h5, 4'h6: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        use_rs1  = 1'b1;
        imm      = DATA_W'(fd_instr[3:0]);
      end
      OpLw: begin
        aluop    = 4'h0;
        alusrc   = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
        memread  = 1'b1;
        use_rs1  = 1'b1;
        imm      = DATA_W'($signed(fd_instr[3:0])) << 1;
      end
      OpSw: begin
        aluop    = 4'h0;
        alusrc   = 1'b1;
        memwrite = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        imm      = DATA_W'($signed(fd_instr[3:0])) << 1;
      end
      OpLlb, OpLhb: begin
        alusrc   = 1'b1;
        regwrite = 1'b1;
        use_rs1  = 1'b1;
        imm      = DATA_W'(fd_instr[7:0]);
      end
      OpBr:    use_rs1 = 1'b1;
      OpPcs: begin
        pcs      = 1'b1;
        regwrite = 1'b1;
      end
      OpHlt:   hlt = 1'b1;
      default: ;
    endcase
  end

  assign ctrl = {aluop, alusrc, memtoreg, pcs, regwrite, memwrite, memread, flag_en, hlt};

  // flags_q = {Z, V, N}
  always_comb begin
    cond = 1'b0;
    case (cc)
      3'b000:  cond = ~flags_q[2];
      3'b001:  cond = flags_q[2];
      3'b010:  cond = ~flags_q[2] & ~flags_q[0];
      3'b011:  cond = flags_q[0];
      3'b100:  cond = flags_q[2] | ~flags_q[0];
      3'b101:  cond = flags_q[0] | flags_q[2];
      3'b110:  cond = flags_q[1];
      default: cond = 1'b1;
    endcase
  end

  assign run     = (state_q == StRun);
  assign hz_load = dx_valid_q & dx_ctrl_q[2] &
                   ((use_rs1 & (dx_rd_q == rs1)) | (use_rs2 & (dx_rd_q == rs2)));
  assign hz_flag = (is_b | is_br) & (cc != 3'b111) & dx_valid_q & dx_ctrl_q[1];
  assign hz_br   = is_br & ((dx_valid_q & dx_ctrl_q[4] & (dx_rd_q == rs1)) |
                            (xm_wr_q & (xm_rd_q == rs1)));
  assign hazard  = fd_valid & run & (hz_load | hz_flag | hz_br);

  assign stall         = ~rst & (~run | hazard);
  assign halt          = ~rst & ~run;
  assign flush         = ~rst & fd_valid & run & ~hazard & (is_b | is_br) & cond;
  assign branch_target = flush ? (is_br ? rf_rd1 : b_tgt) : '0;
  assign issue         = fd_valid & run & ~hazard;

  always_comb begin
    state_d = state_q;
    if (issue && hlt) state_d = StHalted;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      flags_q    <= 3'b000;
      dx_valid_q <= 1'b0;
      dx_ctrl_q  <= '0;
      dx_rd1_q   <= '0;
      dx_rd2_q   <= '0;
      dx_imm_q   <= '0;
      dx_rs1_q   <= '0;
      dx_rs2_q   <= '0;
      dx_rd_q    <= '0;
      xm_wr_q    <= 1'b0;
      xm_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      if (ex_flag_we) flags_q <= ex_flags;
      dx_valid_q <= issue;
      dx_ctrl_q  <= issue ? ctrl : '0;
      dx_rd1_q   <= is_pcs ? fd_pc2 : rf_rd1;
      dx_rd2_q   <= rf_rd2;
      dx_imm_q   <= imm;
      dx_rs1_q   <= rs1;
      dx_rs2_q   <= rs2;
      dx_rd_q    <= rd;
      // EX never stalls, so EX/MEM always follows ID/EX one cycle later.
      xm_wr_q    <= dx_valid_q & dx_ctrl_q[4];
      xm_rd_q    <= dx_rd_q;
    end
  end

  assign dx_valid = dx_valid_q;
  assign dx_ctrl  = dx_ctrl_q;
  assign dx_rd1   = dx_rd1_q;
  assign dx_rd2   = dx_rd2_q;
  assign dx_imm   = dx_imm_q;
  assign dx_rs1   = dx_rs1_q;
  assign dx_rs2   = dx_rs2_q;
  assign dx_rd    = dx_rd_q;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, taken_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      if (stall && run && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Randomized scoreboard bench for decode_hazard_ctrl against a pipeline-history reference model.
module tb_decode_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fd_valid;
  logic [15:0] fd_instr, fd_pc2;
  logic [3:0]  rf_rs1, rf_rs2;
  logic [15:0] rf_rd1, rf_rd2;
  logic        ex_flag_we;
  logic [2:0]  ex_flags;
  logic        stall, flush, halt, dx_valid;
  logic [15:0] branch_target, dx_rd1, dx_rd2, dx_imm;
  logic [3:0]  dx_rs1, dx_rs2, dx_rd;
  logic [11:0] dx_ctrl;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_taken_cnt;
`endif

  logic [15:0] regs [16];
  assign rf_rd1 = regs[rf_rs1];
  assign rf_rd2 = regs[rf_rs2];

  decode_hazard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .fd_valid      (fd_valid),
    .fd_instr      (fd_instr),
    .fd_pc2        (fd_pc2),
    .rf_rs1        (rf_rs1),
    .rf_rs2        (rf_rs2),
    .rf_rd1        (rf_rd1),
    .rf_rd2        (rf_rd2),
    .ex_flag_we    (ex_flag_we),
    .ex_flags      (ex_flags),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .halt          (halt),
    .dx_valid      (dx_valid),
    .dx_rd1        (dx_rd1),
    .dx_rd2        (dx_rd2),
    .dx_imm        (dx_imm),
    .dx_rs1        (dx_rs1),
    .dx_rs2        (dx_rs2),
    .dx_rd         (dx_rd),
    .dx_ctrl       (dx_ctrl)
`ifdef DECODE_PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_taken_cnt(perf_taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  // What the model remembers about an instruction once it has left decode.
  typedef struct packed {
    logic       v;
    logic       ld;
    logic       wr;
    logic       fl;
    logic [3:0] rd;
  } slot_t;

  typedef struct {
    bit          in_rst;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    bit          st;
    bit          fl;
    bit          hl;
    logic [15:0] tgt;
  } cyc_t;

  cyc_t        cq[$];
  logic [71:0] dq[$];
  slot_t       m_ex, m_mem;
  logic [2:0]  m_flags;
  bit          m_halted;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads_a(input logic [3:0] op);
    return !(op inside {4'hC, 4'hE, 4'hF});
  endfunction

  function automatic bit reads_b(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'h9};
  endfunction

  function automatic logic [11:0] ref_ctrl(input logic [3:0] op);
    logic [3:0] alu;
    bit alusrc, wr;
    alu    = (op == 4'h8 || op == 4'h9) ? 4'h0 : op;
    alusrc = op inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};
    wr     = (op <= 4'h8) || op == 4'hA || op == 4'hB || op == 4'hE;
    return {alu, alusrc, op == 4'h8, op == 4'hE, wr, op == 4'h9, op == 4'h8, op <= 4'h2,
            op == 4'hF};
  endfunction

  function automatic logic [15:0] ref_imm(input logic [15:0] ins);
    int o4;
    o4 = int'(ins[3:0]);
    if (ins[3]) o4 -= 16;
    case (ins[15:12])
      4'h4, 4'h5, 4'h6: return {12'h000, ins[3:0]};
      4'h8, 4'h9:       return 16'(2 * o4);
      4'hA, 4'hB:       return {8'h00, ins[7:0]};
      default:          return 16'h0000;
    endcase
  endfunction

  function automatic bit taken(input logic [2:0] cc, input logic [2:0] f);
    bit z, v, n;
    {z, v, n} = f;
    case (cc)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || !n;
      3'd5:    return n || z;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic step(input bit v, input logic [15:0] ins, input logic [15:0] pc2,
                      input bit fwe, input logic [2:0] fl, output bit st, output bit fs);
    logic [3:0]  op, a, b;
    logic [11:0] ct;
    logic [15:0] tgt, rd1;
    bit          lu, fh, bh;
    int          off;
    slot_t       nx;
    @(posedge clk);
    #1;
    rst = 1'b0; fd_valid = v; fd_instr = ins; fd_pc2 = pc2;
    ex_flag_we = fwe; ex_flags = fl;
    op = ins[15:12];
    a  = (op == 4'hA || op == 4'hB) ? ins[11:8] : ins[7:4];
    b  = (op == 4'h8 || op == 4'h9) ? ins[11:8] : ins[3:0];
    ct = ref_ctrl(op);
    lu = m_ex.v && m_ex.ld && ((reads_a(op) && m_ex.rd == a) || (reads_b(op) && m_ex.rd == b));
    fh = (op == 4'hC || op == 4'hD) && ins[11:9] != 3'b111 && m_ex.v && m_ex.fl;
    bh = op == 4'hD && ((m_ex.v && m_ex.wr && m_ex.rd == a) ||
                        (m_mem.v && m_mem.wr && m_mem.rd == a));
    st = m_halted || (v && (lu || fh || bh));
    fs = v && !st && (op == 4'hC || op == 4'hD) && taken(ins[11:9], m_flags);
    off = int'(ins[8:0]);
    if (ins[8]) off -= 512;
    tgt = 16'h0000;
    if (fs) tgt = (op == 4'hD) ? regs[a] : 16'(int'(pc2) + 2 * off);
    cq.push_back('{in_rst: 1'b0, rs1: a, rs2: b, st: st, fl: fs, hl: m_halted, tgt: tgt});
    nx = '0;
    if (v && !st) begin
      rd1 = (op == 4'hE) ? pc2 : regs[a];
      dq.push_back({rd1, regs[b], ref_imm(ins), a, b, ins[11:8], ct});
      nx = '{v: 1'b1, ld: op == 4'h8, wr: ct[4], fl: ct[1], rd: ins[11:8]};
      if (op == 4'hF) m_halted = 1'b1;
    end
    m_mem = m_ex;
    m_ex  = nx;
    if (fwe) m_flags = fl;
  endtask

  // Reset cycles present an always-taken branch and a flag write, both of which must be ignored.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1; fd_valid = 1'b1; fd_instr = 16'hCE00; fd_pc2 = 16'h1234;
      ex_flag_we = 1'b1; ex_flags = 3'b111;
      dq.delete();
      cq.push_back('{in_rst: 1'b1, rs1: 4'h0, rs2: 4'h0, st: 1'b0, fl: 1'b0, hl: 1'b0,
                     tgt: 16'h0000});
      m_ex = '0; m_mem = '0; m_flags = 3'b000; m_halted = 1'b0;
    end
  endtask

  // Fetch behaviour: hold while stalled, squash one slot after a taken branch.
  task automatic issue(input logic [15:0] ins, input logic [15:0] pc2, input bit fwe,
                       input logic [2:0] fl);
    bit st, fs;
    int n;
    n = 0;
    step(1'b1, ins, pc2, fwe, fl, st, fs);
    while (st && n < 6) begin
      step(1'b1, ins, pc2, 1'b0, 3'b000, st, fs);
      n++;
    end
    if (fs) step(1'b0, 16'($urandom), 16'($urandom), 1'b0, 3'b000, st, fs);
  endtask

  initial begin : monitor
    cyc_t c;
    forever begin
      @(negedge clk);
      if (cq.size() > 0) begin
        c = cq.pop_front();
        chk("stall", stall, c.st);
        chk("flush", flush, c.fl);
        chk("halt", halt, c.hl);
        chk("branch_target", branch_target, c.tgt);
        if (c.in_rst) chk("rst_dx_valid", dx_valid, 1'b0);
        else begin
          chk("rf_rs1", rf_rs1, c.rs1);
          chk("rf_rs2", rf_rs2, c.rs2);
        end
      end
      if (dx_valid) begin
        if (dq.size() == 0) chk("dx_unexpected", dx_valid, 1'b0);
        else chk("dx", {dx_rd1, dx_rd2, dx_imm, dx_rs1, dx_rs2, dx_rd, dx_ctrl}, dq.pop_front());
      end else begin
        chk("bubble_ctrl", dx_ctrl, 12'h000);
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : driver
    bit st, fs;
    logic [15:0] ins;
    logic [3:0]  op;
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    rst = 1'b1; fd_valid = 1'b0; fd_instr = 16'h0000; fd_pc2 = 16'h0000;
    ex_flag_we = 1'b0; ex_flags = 3'b000;
    m_ex = '0; m_mem = '0; m_flags = 3'b000; m_halted = 1'b0;
    do_reset(2);

    issue(16'h0123, 16'h0002, 1'b0, 3'b000);         // reset with ADD pending in ID/EX
    do_reset(1);
    issue(16'h8310, 16'h0004, 1'b0, 3'b000);         // LW R3
    issue(16'h0435, 16'h0006, 1'b0, 3'b000);         // ADD R4,R3,R5: load-use
    issue(16'h1123, 16'h000E, 1'b0, 3'b000);         // SUB
    issue(16'hC204, 16'h0010, 1'b1, 3'b100);         // B cc=001 +4 with Z written during stall
    issue(16'hCFFF, 16'h0000, 1'b0, 3'b000);         // B always, offset -1
    issue(16'h0215, 16'h0020, 1'b0, 3'b000);         // ADD R2
    issue(16'hDE20, 16'h0022, 1'b0, 3'b000);         // BR R2: two-cycle source hazard
    issue(16'hF000, 16'h0030, 1'b0, 3'b000);         // HLT
    issue(16'h0123, 16'h0032, 1'b0, 3'b000);         // held off while halted
    do_reset(1);

    for (int i = 0; i < 2500; i++) begin
      op = 4'($urandom_range(0, 14));
      if ($urandom_range(0, 199) == 0) op = 4'hF;
      ins = {op, 12'($urandom)};
      if (op != 4'hC && op != 4'hD && $urandom_range(0, 1) == 1) ins[11:0] = ins[11:0] & 12'h333;
      if ($urandom_range(0, 6) == 0) begin
        step(1'b0, ins, 16'($urandom), 1'($urandom_range(0, 3) == 0), 3'($urandom), st, fs);
      end else begin
        issue(ins, 16'($urandom), 1'($urandom_range(0, 3) == 0), 3'($urandom));
      end
      if (m_halted) begin
        repeat (3) step(1'b1, 16'h0123, 16'h0040, 1'b0, 3'b000, st, fs);
        do_reset(1 + $urandom_range(0, 1));
      end else if ($urandom_range(0, 399) == 0) begin
        do_reset(1);
      end
    end

    repeat (3) step(1'b0, 16'h0000, 16'h0000, 1'b0, 3'b000, st, fs);
    @(negedge clk);
    #1;
    chk("drain", 72'(dq.size()), 72'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
